spi_slave: RTL



---
 rtl/spi_pkg.sv | 33 +++
 rtl/spi_pin_sync.sv | 38 +++
 rtl/spi_slave.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI constants, FSM state type and status bit layout.
// Revision : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_DW = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    // Status bit positions, identical to the master's SPISR register
    localparam int SR_RX_VALID = 0;
    localparam int SR_TX_FULL  = 1;
    localparam int SR_OVERRUN  = 2;
    localparam int SR_UNDERRUN = 3;
    localparam int SR_ABORT    = 4;
    localparam int SR_W        = 5;

    function automatic logic [SPI_DW-1:0] tx_reload(
        input logic              full,
        input logic [SPI_DW-1:0] hold,
        input logic [SPI_DW-1:0] fill
    );
        return full ? hold : fill;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_sync
// Brief    : Multi-stage pin synchroniser with single-cycle rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    // STAGES must be at least 2 for metastability protection
    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], din};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign dout = r_sync[STAGES-1];
    assign rise = r_sync[STAGES-1] & ~r_prev;
    assign fall = ~r_sync[STAGES-1] & r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Brief    : Mode-0 SPI target, oversampled pins, byte TX/RX holding regs.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave
    import spi_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [SPI_DW-1:0] IDLE_FILL   = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SPI_CLK,
    input  logic              SPI_nSS,
    input  logic              SPI_MOSI,
    output logic              SPI_MISO,
    output logic              SPI_MISO_OE,
    input  logic [SPI_DW-1:0] tx_data,
    input  logic              tx_wr,
    output logic              tx_full,
    output logic [SPI_DW-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_rd,
    input  logic              clr_err,
    output logic              overrun,
    output logic              underrun,
    output logic              abort,
    output logic              busy,
    output logic              irq
);

    logic w_sck_level_unused;
    logic w_sck_rise;
    logic w_sck_fall;
    logic w_nss;
    logic w_nss_rise;
    logic w_nss_fall;
    logic w_mosi;
    logic w_mosi_rise_unused;
    logic w_mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI_CLK),
        .dout (w_sck_level_unused),
        .rise (w_sck_rise),
        .fall (w_sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nss (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI_nSS),
        .dout (w_nss),
        .rise (w_nss_rise),
        .fall (w_nss_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst  (rst),
        .din  (SPI_MOSI),
        .dout (w_mosi),
        .rise (w_mosi_rise_unused),
        .fall (w_mosi_fall_unused)
    );

    spi_state_t        r_state;
    spi_state_t        w_state_nxt;
    logic              w_enter;
    logic              w_leave;

    logic [2:0]        r_cnt;
    logic [SPI_DW-1:0] r_tx_sh;
    logic [SPI_DW-1:0] r_rx_sh;
    logic [SPI_DW-1:0] r_tx_hold;
    logic [SPI_DW-1:0] r_rx_data;
    logic [SR_W-1:0]   r_status;
    logic              r_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_nss_fall) begin
                    w_state_nxt = ST_ACTIVE;
                    w_enter     = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_nss_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_leave     = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // SCK edges are ignored outside a frame and in the cycle the frame closes
    logic              w_in_frame;
    logic              w_rise_act;
    logic              w_fall_act;
    logic              w_done;
    logic              w_load;
    logic              w_tx_take;
    logic [SPI_DW-1:0] w_rx_byte;

    assign w_in_frame = (r_state == ST_ACTIVE) && !w_leave;
    assign w_rise_act = w_in_frame && w_sck_rise;
    assign w_fall_act = w_in_frame && w_sck_fall;
    assign w_done     = w_rise_act && (r_cnt == 3'd7);
    assign w_load     = w_enter || w_done;
    assign w_rx_byte  = {r_rx_sh[SPI_DW-2:0], w_mosi};
    // A load frees the holding register in the same cycle, so a coincident write lands
    assign w_tx_take  = tx_wr && (!r_status[SR_TX_FULL] || w_load);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 3'd0;
            r_tx_sh   <= '0;
            r_rx_sh   <= '0;
            r_tx_hold <= '0;
            r_rx_data <= '0;
            r_status  <= '0;
            r_busy    <= 1'b0;
        end else begin
            if (w_tx_take) begin
                r_tx_hold              <= tx_data;
                r_status[SR_TX_FULL]   <= 1'b1;
            end else if (w_load) begin
                r_status[SR_TX_FULL]   <= 1'b0;
            end

            if (w_enter) begin
                r_cnt <= 3'd0;
            end else if (w_rise_act) begin
                r_cnt <= r_cnt + 3'd1;
            end

            if (w_load) begin
                r_tx_sh <= tx_reload(r_status[SR_TX_FULL], r_tx_hold, IDLE_FILL);
            end else if (w_fall_act && (r_cnt != 3'd0)) begin
                r_tx_sh <= {r_tx_sh[SPI_DW-2:0], 1'b0};
            end

            if (w_rise_act) begin
                r_rx_sh <= w_rx_byte;
            end

            if (w_done && (!r_status[SR_RX_VALID] || rx_rd)) begin
                r_rx_data             <= w_rx_byte;
                r_status[SR_RX_VALID] <= 1'b1;
            end else if (rx_rd) begin
                r_status[SR_RX_VALID] <= 1'b0;
            end

            // Sticky flags: a set event outranks a simultaneous clear
            r_status[SR_OVERRUN]  <= (w_done && r_status[SR_RX_VALID] && !rx_rd)
                                   | (r_status[SR_OVERRUN] & ~clr_err);
            r_status[SR_UNDERRUN] <= (w_load && !r_status[SR_TX_FULL])
                                   | (r_status[SR_UNDERRUN] & ~clr_err);
            r_status[SR_ABORT]    <= (w_leave && (r_cnt != 3'd0))
                                   | (r_status[SR_ABORT] & ~clr_err);

            r_busy <= ~w_nss;
        end
    end

    assign SPI_MISO    = (r_state == ST_ACTIVE) ? r_tx_sh[SPI_DW-1] : 1'b1;
    assign SPI_MISO_OE = (r_state == ST_ACTIVE);
    assign tx_full     = r_status[SR_TX_FULL];
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_status[SR_RX_VALID];
    assign overrun     = r_status[SR_OVERRUN];
    assign underrun    = r_status[SR_UNDERRUN];
    assign abort       = r_status[SR_ABORT];
    assign busy        = r_busy;
    assign irq         = r_status[SR_RX_VALID] | r_status[SR_OVERRUN] | r_status[SR_ABORT];

endmodule
`default_nettype wire
